// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite/background ROM between
// N requesters. Issues registered ROM reads, tracks the owner of each read
// through the fixed ROM latency, and hands back data with a one-hot valid.
module sprite_rom_arbiter #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned DATA_W  = 5,
  parameter int unsigned ROM_LAT = 2
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      arb_en,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  output logic [N_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_rd,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [DATA_W-1:0]         rdata,
  output logic [N_REQ-1:0]          rvalid,
  output logic                      busy
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned IDX_W = PTR_W + 1;
  localparam int unsigned TAG_D = ROM_LAT + 1;

  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_d;
  logic [N_REQ-1:0]  cand;
  logic [IDX_W-1:0]  scan_idx;
  logic [PTR_W-1:0]  win_idx;
  logic              win_vld;
  logic [ADDR_W-1:0] addr_sel;
  logic [N_REQ-1:0]  tag_q [TAG_D];
  logic [N_REQ-1:0]  tag_or;

  // No candidates while disabled or held in reset, so gnt is forced low.
  assign cand = (arb_en && Reset_n) ? req : '0;

  // Round-robin scan starting at ptr; first set candidate wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_idx = IDX_W'(ptr_q) + IDX_W'(i);
      if (scan_idx >= IDX_W'(N_REQ)) begin
        scan_idx = scan_idx - IDX_W'(N_REQ);
      end
      if (!win_vld && cand[PTR_W'(scan_idx)]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(scan_idx);
      end
    end
  end

  // One-hot grant from the winning index.
  always_comb begin
    gnt = '0;
    if (win_vld) begin
      gnt[win_idx] = 1'b1;
    end
  end

  // Address mux for the winning requester.
  always_comb begin
    addr_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        addr_sel = addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Pointer moves just past the winner; holds when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (win_vld) begin
      if (win_idx == PTR_W'(N_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_idx + PTR_W'(1);
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // ROM issue: strobe follows the grant, address holds between grants.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      rom_rd   <= 1'b0;
    end else begin
      rom_rd <= win_vld;
      if (win_vld) begin
        rom_addr <= addr_sel;
      end
    end
  end

  // Owner tags ride alongside the read until the ROM data is valid.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned s = 0; s < TAG_D; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= gnt;
      for (int unsigned s = 1; s < TAG_D; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // Capture returning data for its owner; rdata holds between returns.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      rvalid <= tag_q[ROM_LAT];
      if (|tag_q[ROM_LAT]) begin
        rdata <= rom_q;
      end
    end
  end

  // Busy while any tag is in flight or a return is being presented.
  always_comb begin
    tag_or = '0;
    for (int unsigned s = 0; s < TAG_D; s++) begin
      tag_or = tag_or | tag_q[s];
    end
    busy = (|tag_or) || (|rvalid);
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one single-port sprite/background ROM (5-bit palette-index words) between N requesters: background renderer, chooser/menu overlay and the battle sprite engine inside the game-state path.
- Performs round-robin arbitration, drives the ROM address and read strobe, and tracks in-flight reads through the fixed ROM latency.
- Returns each data word to the requester that issued the read, tagged with a one-hot valid.
- Sits between game-state logic and the ROM instance, ahead of the color palette.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- ADDR_W, 19, ROM word-address width.
- DATA_W, 5, ROM word width (palette index).
- ROM_LAT, 2, cycles from rom_rd high to rom_q valid (1..4).

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  asynchronous active-low reset
- arb_en  in  1  when low, no new grants; in-flight reads still complete
- req  in  N_REQ  per-requester read request, held until granted
- addr  in  N_REQ*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot combinational grant; request accepted this cycle
- rom_addr  out  ADDR_W  registered ROM address
- rom_rd  out  1  registered ROM read strobe
- rom_q  in  DATA_W  ROM read data
- rdata  out  DATA_W  registered return data
- rvalid  out  N_REQ  one-hot, marks the owner of rdata this cycle
- busy  out  1  high while any read is in flight

Behaviour:
- Reset (asynchronous, Reset_n low):
  - rom_addr=0, rom_rd=0, rdata=0, rvalid=0, busy=0.
  - Round-robin pointer=0; tag pipeline cleared.
  - gnt forced to 0 while Reset_n is low.
- Arbitration (combinational, every cycle):
  - Candidate set = req when arb_en=1 and Reset_n=1, otherwise empty.
  - Scan order is ptr, ptr+1, ..., wrapping modulo N_REQ; the first set bit wins. At most one gnt bit is high.
  - Handshake: req/addr held stable until gnt. A request seen with gnt in the same cycle is consumed. If req is still high on the next cycle, that is a new request.
- Pointer: on a grant to index k, ptr <= (k+1) mod N_REQ. With no grant, ptr holds.
- Issue (grant in cycle T):
  - At the edge ending T: rom_addr <= addr of k, rom_rd <= 1. rom_rd=0 in any cycle following a no-grant cycle.
  - rom_addr holds its last value when no grant.
- Tag pipeline:
  - One-hot tag shift register of depth ROM_LAT+1 carries the gnt vector.
  - rom_q is valid in cycle T+1+ROM_LAT.
  - At the edge ending that cycle: rdata <= rom_q, rvalid <= tag.
  - Required latency: gnt at T gives rvalid/rdata in cycle T+2+ROM_LAT (T+4 at default).
- Throughput: one grant per cycle sustained; back-to-back grants to different or same requesters are allowed. Returns are in issue order.
- rvalid is a single-cycle pulse per grant. rdata holds its value when rvalid=0.
- busy = OR of all tag pipeline stages and rvalid.
- arb_en falling mid-stream: grants stop the same cycle; all already-granted reads still return.
- Requester dropping req before grant: legal, no side effects.
- Reset mid-operation: all in-flight reads are discarded; no rvalid after reset release until new grants are made.
- Single requester: granted every cycle it requests; ptr wrap does not cause starvation or bubbles.
- Fairness: any continuously requesting requester is granted within N_REQ cycles.

Test Plan:
- Reset: hold Reset_n=0 with req=3'b111 -> gnt=0, rom_rd=0, rvalid=0, busy=0. After release with arb_en=1, first grant is gnt=3'b001.
- Single read: req=3'b010, addr1=19'h1234, ROM model returns 5'd17 at default latency. Expect gnt=3'b010 at T, rom_addr=19'h1234 and rom_rd=1 at T+1, rvalid=3'b010 and rdata=17 at T+4, busy low by T+5.
- Round-robin: req=3'b111 held for 6 cycles -> gnt sequence 001,010,100,001,010,100, and rvalid follows the same sequence offset by 4 cycles.
- Back-to-back single requester: req0 held high with addresses 0,1,2,3 -> grants in 4 consecutive cycles, rvalid=001 for 4 consecutive cycles, rdata matching ROM[0..3] in order.
- arb_en gating: 3 grants issued, then arb_en=0 with req=3'b111 -> gnt=0 immediately, the 3 outstanding rvalid pulses still arrive, busy then falls to 0.
- Reset mid-flight: assert Reset_n=0 one cycle after a grant, release 2 cycles later with req=0 -> no rvalid pulse ever appears, rdata=0.
